alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational 8-bit ALU.
- Keeps the eight original opcodes (NOP/LD/ADD/SUB/NOT/AND/OR/XOR) and their carry and overflow semantics.
- Adds barrel shifts and rotates, an iterative shift-add multiplier, a start/busy/done handshake, and registered zero and negative flags.
- Sits between the datapath register file and the flags register.

Parameters:
WIDTH, 8, operand/result width; power of two, >= 4
SHW, $clog2(WIDTH), derived; shift-amount width (not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request; accepted only when busy=0
op  in  4  operation code
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B / shift amount in in_b[SHW-1:0]
ci  in  1  carry/borrow in (ADD/SUB only)
busy  out  1  multiply in progress
done  out  1  one-cycle pulse: result/flags just updated
result  out  WIDTH  registered result
co  out  1  carry/borrow/shift-out
ov  out  1  signed overflow
zf  out  1  result == 0
nf  out  1  result[WIDTH-1]

Behaviour:
- One clock; reset is synchronous and active-high on rst.
- Reset: busy, done, result, co, ov, zf, nf all 0; FSM to IDLE. rst has priority over start and over any in-flight multiply. A cancelled multiply produces no done pulse.
- FSM states: IDLE, MUL.
- Acceptance: start=1 and busy=0 at edge k. Operands, op and ci are latched at edge k. start while busy=1 is ignored (no queueing). start in a done cycle is accepted.
- Single-cycle ops (op != 1100/1101):
  - result and flags are registered at edge k; done=1 for the following cycle; FSM stays IDLE.
- Multiply ops (1100 MULL, 1101 MULH):
  - IDLE->MUL at edge k; busy=1 from after edge k until edge k+WIDTH.
  - One shift-add iteration per edge on a 2*WIDTH unsigned product, iteration counter 0..WIDTH-1.
  - At edge k+WIDTH: result and flags are registered, busy=0, done=1 for one cycle, FSM to IDLE.
- Outputs hold their last values between operations. done=0 whenever no op completed at the previous edge.
- Opcodes:
  - 0000 NOP, 0001 LD: result=in_b; co=ov=0.
  - 0010 ADD: {co,result}=a+b+ci (WIDTH+1 bits). ov=1 when a and b have the same sign and result's sign differs.
  - 0011 SUB: {co,result}=a-b-ci; co is the borrow. ov=1 when a and b signs differ and result's sign differs from a.
  - 0100 NOT ~a; 0101 AND; 0110 OR; 0111 XOR: co=ov=0.
  - 1000 SHL, 1001 SHR (logical), 1010 SAR (arithmetic), 1011 ROL:
    - amount n=in_b[SHW-1:0]; upper in_b bits are ignored.
    - co = last bit shifted out (ROL: bit rotated into LSB, i.e. result[0]); n=0 gives result=a, co=0.
    - ov=0.
  - 1100 MULL: result = low WIDTH bits of a*b; co=ov=(high half != 0).
  - 1101 MULH: result = high WIDTH bits of a*b; co=ov=0.
  - 1110, 1111 reserved: single-cycle, result=0, co=ov=0, zf=1, nf=0.
- zf and nf are always computed from the new result, for every op including LD/NOP.
- Width arithmetic: all operands unsigned except the ov and SAR sign interpretation. No implicit sign extension of in_b.

Test Plan:
- rst 2 cycles, then ADD a=0x7F b=0x01 ci=0 -> next cycle done=1, result=0x80, co=0, ov=1, nf=1, zf=0; done=0 the cycle after.
- SUB a=0x00 b=0x01 ci=0 -> result=0xFF, co=1, ov=0, nf=1. ADD a=0xFF b=0x00 ci=1 -> result=0x00, co=1, zf=1.
- SAR a=0x81 b=0x01 -> 0xC0, co=1. SHR same -> 0x40, co=1. ROL a=0x81 b=0x09 (n=1) -> 0x03, co=1. SHL b=0x00 -> 0x81, co=0.
- MULL a=0x10 b=0x10 accepted at edge k -> busy=1 for 8 cycles. At edge k+8: result=0x00, co=ov=1, zf=1, done=1. MULH same operands -> result=0x01. MULL 0xFF*0xFF -> 0x01, co=1.
- During MULL (busy=1), drive start with ADD 0x01+0x01 -> ignored, MULL result unaffected. A new ADD asserted in the done cycle -> accepted, result=0x02 next cycle.
- rst asserted at cycle 4 of a multiply -> after that edge busy=0, done=0, result=0, flags 0. No done pulse in the following 10 cycles. Idle start=0 -> outputs stay unchanged.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with barrel shifts/rotates and an iterative shift-add multiplier.
// A start/busy/done handshake sequences the operations; zero and negative flags are registered.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ov,
    output logic             zf,
    output logic             nf
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned XW  = WIDTH + 1;
    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_LD   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SHL  = 4'b1000;
    localparam logic [3:0] OP_SHR  = 4'b1001;
    localparam logic [3:0] OP_SAR  = 4'b1010;
    localparam logic [3:0] OP_ROL  = 4'b1011;
    localparam logic [3:0] OP_MULL = 4'b1100;
    localparam logic [3:0] OP_MULH = 4'b1101;

    typedef enum logic [0:0] {IDLE, MUL} state_t;

    state_t           state, state_d;
    logic             busy_d, done_d, co_d, ov_d, zf_d, nf_d;
    logic [WIDTH-1:0] result_d;
    logic [PW-1:0]    mcand, mcand_d, prod, prod_d, prod_nx;
    logic [WIDTH-1:0] mplier, mplier_d, mul_res;
    logic [SHW-1:0]   cnt, cnt_d;
    logic             mul_hi, mul_hi_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_co, alu_ov;
    logic [XW-1:0]    wide;
    logic [PW-1:0]    dbl;
    logic [SHW-1:0]   n;

    // Single-cycle datapath; the extra bit of 'wide' carries co/borrow or the shifted-out bit.
    always_comb begin
        alu_res = '0;
        alu_co  = 1'b0;
        alu_ov  = 1'b0;
        wide    = '0;
        dbl     = '0;
        n       = in_b[SHW-1:0];
        case (op)
            OP_NOP, OP_LD: alu_res = in_b;
            OP_ADD: begin
                wide    = {1'b0, in_a} + {1'b0, in_b} + XW'(ci);
                alu_res = wide[WIDTH-1:0];
                alu_co  = wide[WIDTH];
                alu_ov  = (in_a[MSB] == in_b[MSB]) && (wide[MSB] != in_a[MSB]);
            end
            OP_SUB: begin
                wide    = {1'b0, in_a} - {1'b0, in_b} - XW'(ci);
                alu_res = wide[WIDTH-1:0];
                alu_co  = wide[WIDTH];
                alu_ov  = (in_a[MSB] != in_b[MSB]) && (wide[MSB] != in_a[MSB]);
            end
            OP_NOT: alu_res = ~in_a;
            OP_AND: alu_res = in_a & in_b;
            OP_OR:  alu_res = in_a | in_b;
            OP_XOR: alu_res = in_a ^ in_b;
            OP_SHL: begin
                wide    = {1'b0, in_a} << n;
                alu_res = wide[WIDTH-1:0];
                alu_co  = wide[WIDTH];
            end
            OP_SHR: begin
                wide    = {in_a, 1'b0} >> n;
                alu_res = wide[WIDTH:1];
                alu_co  = wide[0];
            end
            OP_SAR: begin
                wide    = XW'($signed({in_a, 1'b0}) >>> n);
                alu_res = wide[WIDTH:1];
                alu_co  = wide[0];
            end
            OP_ROL: begin
                dbl     = {in_a, in_a} << n;
                alu_res = dbl[PW-1:WIDTH];
                alu_co  = (n != '0) & dbl[WIDTH];
            end
            default: alu_res = '0;
        endcase
    end

    // Next-state and next-output logic; multiply runs one shift-add step per cycle.
    always_comb begin
        state_d  = state;
        busy_d   = busy;
        done_d   = 1'b0;
        result_d = result;
        co_d     = co;
        ov_d     = ov;
        zf_d     = zf;
        nf_d     = nf;
        mcand_d  = mcand;
        mplier_d = mplier;
        prod_d   = prod;
        cnt_d    = cnt;
        mul_hi_d = mul_hi;
        prod_nx  = '0;
        mul_res  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MULL || op == OP_MULH) begin
                        state_d  = MUL;
                        busy_d   = 1'b1;
                        mcand_d  = PW'(in_a);
                        mplier_d = in_b;
                        prod_d   = '0;
                        cnt_d    = '0;
                        mul_hi_d = op[0];
                    end else begin
                        result_d = alu_res;
                        co_d     = alu_co;
                        ov_d     = alu_ov;
                        zf_d     = (alu_res == '0);
                        nf_d     = alu_res[MSB];
                        done_d   = 1'b1;
                    end
                end
            end
            MUL: begin
                prod_nx  = prod + (mplier[0] ? mcand : '0);
                prod_d   = prod_nx;
                mcand_d  = mcand << 1;
                mplier_d = mplier >> 1;
                cnt_d    = cnt + SHW'(1);
                if (cnt == SHW'(WIDTH - 1)) begin
                    mul_res  = mul_hi ? prod_nx[PW-1:WIDTH] : prod_nx[WIDTH-1:0];
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = mul_res;
                    co_d     = !mul_hi && (prod_nx[PW-1:WIDTH] != '0);
                    ov_d     = !mul_hi && (prod_nx[PW-1:WIDTH] != '0);
                    zf_d     = (mul_res == '0);
                    nf_d     = mul_res[MSB];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            co     <= 1'b0;
            ov     <= 1'b0;
            zf     <= 1'b0;
            nf     <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            mul_hi <= 1'b0;
        end else begin
            state  <= state_d;
            busy   <= busy_d;
            done   <= done_d;
            result <= result_d;
            co     <= co_d;
            ov     <= ov_d;
            zf     <= zf_d;
            nf     <= nf_d;
            mcand  <= mcand_d;
            mplier <= mplier_d;
            prod   <= prod_d;
            cnt    <= cnt_d;
            mul_hi <= mul_hi_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal expectations, then random traffic
// compared every cycle against an arithmetic model of the operation semantics.
module tb_alu_seq;

    localparam int W = 8;
    localparam int MASK = 255;

    logic         clk, rst, start, ci;
    logic [3:0]   op;
    logic [W-1:0] in_a, in_b;
    logic         busy, done, co, ov, zf, nf;
    logic [W-1:0] result;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in_a(in_a), .in_b(in_b), .ci(ci),
        .busy(busy), .done(done), .result(result), .co(co), .ov(ov), .zf(zf), .nf(nf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model state: what the outputs must show after each edge.
    int m_busy = 0, m_done = 0, m_res = 0, m_co = 0, m_ov = 0, m_zf = 0, m_nf = 0;
    int m_left = 0, p_res = 0, p_co = 0, p_ov = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    function automatic bit out_of_range(input int v);
        return (v > 127) || (v < -128);
    endfunction

    // Operation semantics in plain integer arithmetic.
    function automatic void alu_model(input int o, input int a, input int b, input int c,
                                      output int r, output int cy, output int v);
        int n, sa, sb, t, p;
        n  = b % W;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = 0; cy = 0; v = 0;
        case (o)
            0, 1: r = b;
            2: begin t = a + b + c; r = t & MASK; cy = t / 256; v = out_of_range(sa + sb + c); end
            3: begin t = a - b - c; r = t & MASK; cy = (t < 0); v = out_of_range(sa - sb - c); end
            4: r = (~a) & MASK;
            5: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            8: begin r = (a << n) & MASK; cy = (n != 0) ? (a >> (W - n)) & 1 : 0; end
            9: begin r = a >> n; cy = (n != 0) ? (a >> (n - 1)) & 1 : 0; end
            10: begin r = (sa >>> n) & MASK; cy = (n != 0) ? (a >> (n - 1)) & 1 : 0; end
            11: begin r = ((a << n) | (a >> (W - n))) & MASK; cy = (n != 0) ? r & 1 : 0; end
            12: begin p = a * b; r = p & MASK; cy = (p / 256) != 0; v = cy; end
            13: begin p = a * b; r = p / 256; end
            default: r = 0;
        endcase
    endfunction

    task automatic apply(input int r, input int cy, input int v);
        m_res = r; m_co = cy; m_ov = v;
        m_zf = (r == 0); m_nf = (r >> (W - 1)) & 1;
        m_done = 1;
    endtask

    task automatic model_edge();
        int r, cy, v;
        if (rst) begin
            m_busy = 0; m_done = 0; m_res = 0; m_co = 0; m_ov = 0; m_zf = 0; m_nf = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy != 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    apply(p_res, p_co, p_ov);
                end
            end else if (start) begin
                alu_model(int'(op), int'(in_a), int'(in_b), int'(ci), r, cy, v);
                if (op == 4'd12 || op == 4'd13) begin
                    m_busy = 1; m_left = W; p_res = r; p_co = cy; p_ov = v;
                end else begin
                    apply(r, cy, v);
                end
            end
        end
    endtask

    always @(posedge clk) model_edge();

    // Full output comparison on every falling edge once checking is enabled.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(busy), m_busy);
            chk("done", int'(done), m_done);
            chk("result", int'(result), m_res);
            chk("co", int'(co), m_co);
            chk("ov", int'(ov), m_ov);
            chk("zf", int'(zf), m_zf);
            chk("nf", int'(nf), m_nf);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b, input logic c);
        start = 1'b1; op = o; in_a = a; in_b = b; ci = c;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (done) break;
        end
    endtask

    initial begin
        int lat, pulses;
        rst = 1'b1; start = 1'b0; op = 4'd0; in_a = '0; in_b = '0; ci = 1'b0;
        step(); step();
        chk_en = 1'b1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), 0);
        rst = 1'b0;

        issue(4'd2, 8'h7F, 8'h01, 1'b0);
        chk("add_done", int'(done), 1);
        chk("add_res", int'(result), 'h80);
        chk("add_ov", int'(ov), 1);
        chk("add_nf", int'(nf), 1);
        step();
        chk("add_done_drop", int'(done), 0);

        issue(4'd3, 8'h00, 8'h01, 1'b0);
        chk("sub_res", int'(result), 'hFF);
        chk("sub_borrow", int'(co), 1);
        issue(4'd2, 8'hFF, 8'h00, 1'b1);
        chk("addc_res", int'(result), 0);
        chk("addc_co", int'(co), 1);
        chk("addc_zf", int'(zf), 1);
        issue(4'd10, 8'h81, 8'h01, 1'b0);
        chk("sar_res", int'(result), 'hC0);
        chk("sar_co", int'(co), 1);
        issue(4'd9, 8'h81, 8'h01, 1'b0);
        chk("shr_res", int'(result), 'h40);
        issue(4'd11, 8'h81, 8'h09, 1'b0);
        chk("rol_res", int'(result), 'h03);
        chk("rol_co", int'(co), 1);
        issue(4'd8, 8'h81, 8'h00, 1'b0);
        chk("shl0_res", int'(result), 'h81);
        chk("shl0_co", int'(co), 0);

        issue(4'd12, 8'h10, 8'h10, 1'b0);
        chk("mul_busy", int'(busy), 1);
        for (int i = 1; i <= W; i++) begin
            if (i >= 3) begin
                start = 1'b1; op = 4'd2; in_a = 8'h01; in_b = 8'h01; ci = 1'b0;
            end
            step();
            if (i < W) chk("mul_busy_hold", int'(busy), 1);
        end
        start = 1'b0;
        chk("mull_done", int'(done), 1);
        chk("mull_busy_clr", int'(busy), 0);
        chk("mull_res", int'(result), 0);
        chk("mull_ov", int'(ov), 1);
        chk("mull_zf", int'(zf), 1);
        issue(4'd2, 8'h01, 8'h01, 1'b0);
        chk("add_in_done", int'(result), 2);

        issue(4'd13, 8'h10, 8'h10, 1'b0);
        wait_done(lat);
        chk("mulh_lat", lat, W);
        chk("mulh_res", int'(result), 1);
        issue(4'd12, 8'hFF, 8'hFF, 1'b0);
        wait_done(lat);
        chk("mull_ff_res", int'(result), 1);
        chk("mull_ff_co", int'(co), 1);

        issue(4'd12, 8'h10, 8'h10, 1'b0);
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("cancel_busy", int'(busy), 0);
        chk("cancel_result", int'(result), 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            pulses += int'(done);
        end
        chk("cancel_no_done", pulses, 0);

        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(63) == 0);
            start = ($urandom_range(2) != 0);
            op    = 4'($urandom_range(15));
            in_a  = 8'($urandom);
            in_b  = 8'($urandom);
            ci    = 1'($urandom);
            if ($urandom_range(7) == 0) in_a = ($urandom_range(1) != 0) ? 8'h7F : 8'h80;
            if ($urandom_range(7) == 0) in_b = ($urandom_range(1) != 0) ? 8'hFF : 8'h00;
            step();
        end
        rst = 1'b0; start = 1'b0;
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
